// File: rtl/riscv_pkg.sv
// Shared machine-mode CSR constants: addresses, interrupt cause codes, bit positions.
package riscv_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] IRQ_M_TIMER = 4'd7;
  localparam logic [3:0] IRQ_M_EXT   = 4'd11;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  // mie / mip bit positions (mip uses the same layout)
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;

endpackage

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt picker: external beats timer.
module irq_arbiter
  import riscv_pkg::*;
(
  input  logic       ext_pend,
  input  logic       timer_pend,
  output logic       valid,
  output logic [3:0] code
);

  // Select the highest-priority enabled-and-pending source
  always_comb begin
    valid = ext_pend | timer_pend;
    code  = '0;
    if (ext_pend)
      code = IRQ_M_EXT;
    else if (timer_pend)
      code = IRQ_M_TIMER;
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with CSRRW access, interrupt entry and mret return.
module csr_file
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic            inst_valid,
  input  logic            csr_rd,
  input  logic            csr_wr,
  input  logic            is_mret,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] pc,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  logic [11:0]      csr_addr;
  logic             unused_inst;

  logic             mst_mie, mst_mpie;
  logic             mie_mtie, mie_meie;
  logic             mip_mtip, mip_meip;
  logic [XLEN-1:0]  mtvec;
  logic [XLEN-1:2]  mepc;
  logic             mcause_irq;
  logic [3:0]       mcause_code;

  logic             irq_valid;
  logic [3:0]       irq_code;
  logic             take_irq;
  logic             do_mret;
  logic             do_write;
  logic [XLEN-1:0]  rd_val;
  logic [XLEN-1:0]  trap_pc;

  assign csr_addr    = inst[31:20];
  assign unused_inst = ^inst[19:0];

  irq_arbiter u_irq_arbiter (
    .ext_pend   (mip_meip & mie_meie),
    .timer_pend (mip_mtip & mie_mtie),
    .valid      (irq_valid),
    .code       (irq_code)
  );

  assign take_irq = mst_mie & irq_valid & inst_valid;
  assign do_mret  = is_mret & inst_valid & ~take_irq;
  assign do_write = csr_wr & inst_valid & ~take_irq;

  // Trap target: base aligned to 4, plus 4*code in vectored mode
  always_comb begin
    trap_pc = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01)
      trap_pc = trap_pc + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
  end

  // Redirect request and target for the PC-select logic
  always_comb begin
    redirect    = take_irq | (is_mret & inst_valid);
    redirect_pc = '0;
    if (take_irq)
      redirect_pc = trap_pc;
    else if (is_mret & inst_valid)
      redirect_pc = {mepc, 2'b00};
  end

  // Combinational read mux; unimplemented bits and addresses read 0
  always_comb begin
    rd_val = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]  = mst_mie;
        rd_val[MSTATUS_MPIE] = mst_mpie;
      end
      CSR_MIE: begin
        rd_val[MIE_MTIE] = mie_mtie;
        rd_val[MIE_MEIE] = mie_meie;
      end
      CSR_MTVEC:  rd_val = mtvec;
      CSR_MEPC:   rd_val = {mepc, 2'b00};
      CSR_MCAUSE: begin
        rd_val[XLEN-1] = mcause_irq;
        rd_val[3:0]    = mcause_code;
      end
      CSR_MIP: begin
        rd_val[MIE_MTIE] = mip_mtip;
        rd_val[MIE_MEIE] = mip_meip;
      end
      default: rd_val = '0;
    endcase
    csr_rdata = csr_rd ? rd_val : '0;
  end

  // Sample interrupt lines every cycle, independent of stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mip_mtip <= 1'b0;
      mip_meip <= 1'b0;
    end else begin
      mip_mtip <= timer_irq;
      mip_meip <= ext_irq;
    end
  end

  // CSR state: trap entry overrides mret and software writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie     <= 1'b0;
      mst_mpie    <= 1'b0;
      mie_mtie    <= 1'b0;
      mie_meie    <= 1'b0;
      mtvec       <= MTVEC_RST;
      mepc        <= '0;
      mcause_irq  <= 1'b0;
      mcause_code <= '0;
    end else if (take_irq) begin
      mepc        <= pc[XLEN-1:2];
      mcause_irq  <= 1'b1;
      mcause_code <= irq_code;
      mst_mpie    <= mst_mie;
      mst_mie     <= 1'b0;
    end else if (do_mret) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mst_mie  <= csr_wdata[MSTATUS_MIE];
          mst_mpie <= csr_wdata[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          mie_mtie <= csr_wdata[MIE_MTIE];
          mie_meie <= csr_wdata[MIE_MEIE];
        end
        CSR_MTVEC:  mtvec <= csr_wdata;
        CSR_MEPC:   mepc  <= csr_wdata[XLEN-1:2];
        CSR_MCAUSE: begin
          mcause_irq  <= csr_wdata[XLEN-1];
          mcause_code <= csr_wdata[3:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: each driven cycle pushes its expected outputs,
// the negedge monitor pops and compares.
module tb_csr_file;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid, csr_rd, csr_wr, is_mret;
  logic [31:0] csr_wdata, pc;
  logic        timer_irq, ext_irq;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];

  csr_file #(.XLEN(32), .MTVEC_RST(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .csr_rd      (csr_rd),
    .csr_wr      (csr_wr),
    .is_mret     (is_mret),
    .csr_wdata   (csr_wdata),
    .pc          (pc),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Monitor: compare combinational outputs mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, ".rdata"}, csr_rdata, e.rdata);
      check_eq({e.tag, ".redir"}, {31'b0, redirect}, {31'b0, e.redir});
      check_eq({e.tag, ".rpc"}, redirect_pc, e.rpc);
    end
  end

  task automatic step(input string tag, input logic v, input logic rd, input logic wr,
                      input logic mret, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [31:0] p, input logic ti, input logic ei,
                      input logic [31:0] e_rd, input logic e_redir, input logic [31:0] e_rpc);
    exp_t e;
    @(posedge clk);
    #1;
    inst       = {addr, 20'h00073};
    inst_valid = v;
    csr_rd     = rd;
    csr_wr     = wr;
    is_mret    = mret;
    csr_wdata  = wd;
    pc         = p;
    timer_irq  = ti;
    ext_irq    = ei;
    e.tag   = tag;
    e.rdata = e_rd;
    e.redir = e_redir;
    e.rpc   = e_rpc;
    sb.push_back(e);
  endtask

  task automatic read_in_reset(input string tag, input logic [11:0] addr);
    csr_rd = 1'b1;
    inst   = {addr, 20'h00073};
    #1;
    check_eq(tag, csr_rdata, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    inst = {CSR_MTVEC, 20'h00073};
    inst_valid = 1'b0; csr_rd = 1'b1; csr_wr = 1'b0; is_mret = 1'b0;
    csr_wdata = '0; pc = '0; timer_irq = 1'b0; ext_irq = 1'b0;
    #3;
    check_eq("rst.rdata", csr_rdata, 32'h0);
    check_eq("rst.redir", {31'b0, redirect}, 32'h0);
    check_eq("rst.rpc", redirect_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //    tag             v  rd wr mr addr         wdata         pc    ti ei  exp_rd        rd  exp_rpc
    step("rt_wr",         1, 1, 1, 0, CSR_MTVEC,   32'h100,      0,    0, 0,  32'h0,        0, 32'h0);
    step("rt_rd",         1, 1, 0, 0, CSR_MTVEC,   0,            0,    0, 0,  32'h100,      0, 32'h0);
    step("unmap_wr",      1, 1, 1, 0, 12'h340,     32'hDEADBEEF, 0,    0, 0,  32'h0,        0, 32'h0);
    step("unmap_rd",      1, 1, 0, 0, 12'h340,     0,            0,    0, 0,  32'h0,        0, 32'h0);
    step("mie_wr_all",    1, 1, 1, 0, CSR_MIE,     32'hFFFFFFFF, 0,    0, 0,  32'h0,        0, 32'h0);
    step("mie_mask",      1, 1, 1, 0, CSR_MIE,     32'h80,       0,    0, 0,  32'h880,      0, 32'h0);
    step("mst_wr_all",    1, 1, 1, 0, CSR_MSTATUS, 32'hFFFFFFFF, 0,    0, 0,  32'h0,        0, 32'h0);
    step("mst_mask",      1, 1, 1, 0, CSR_MSTATUS, 32'h8,        0,    0, 0,  32'h88,       0, 32'h0);
    step("mip_wr",        1, 1, 1, 0, CSR_MIP,     32'hFFFFFFFF, 0,    0, 0,  32'h0,        0, 32'h0);
    step("tmr_assert",    1, 1, 0, 0, CSR_MIP,     0,            32'h40, 1, 0, 32'h0,        0, 32'h0);
    step("tmr_trap",      1, 1, 0, 0, CSR_MSTATUS, 0,            32'h40, 1, 0, 32'h8,        1, 32'h100);
    step("tmr_mepc",      1, 1, 0, 0, CSR_MEPC,    0,            32'h44, 1, 0, 32'h40,       0, 32'h0);
    step("tmr_mcause",    1, 1, 0, 0, CSR_MCAUSE,  0,            32'h48, 1, 0, 32'h80000007, 0, 32'h0);
    step("tmr_mst",       1, 1, 0, 0, CSR_MSTATUS, 0,            32'h4C, 1, 0, 32'h80,       0, 32'h0);
    step("mip_tmr",       1, 1, 0, 0, CSR_MIP,     0,            32'h50, 0, 0, 32'h80,       0, 32'h0);
    step("mret",          1, 1, 0, 1, CSR_MSTATUS, 0,            32'h80, 0, 0, 32'h80,       1, 32'h40);
    step("mret_mst",      1, 1, 0, 0, CSR_MSTATUS, 0,            32'h40, 0, 0, 32'h88,       0, 32'h0);
    step("mepc_wr",       1, 1, 1, 0, CSR_MEPC,    32'h103,      0,    0, 0,  32'h40,       0, 32'h0);
    step("mepc_mask",     1, 1, 0, 0, CSR_MEPC,    0,            0,    0, 0,  32'h100,      0, 32'h0);
    step("vec_tvec",      1, 1, 1, 0, CSR_MTVEC,   32'h201,      0,    0, 0,  32'h100,      0, 32'h0);
    step("vec_mie",       1, 1, 1, 0, CSR_MIE,     32'h880,      0,    0, 0,  32'h80,       0, 32'h0);
    step("stall_a",       0, 1, 1, 0, CSR_MEPC,    32'h123,      32'h60, 1, 1, 32'h100,      0, 32'h0);
    step("stall_b",       0, 1, 1, 1, CSR_MEPC,    32'h456,      32'h60, 1, 1, 32'h100,      0, 32'h0);
    step("vec_trap",      1, 1, 1, 0, CSR_MEPC,    32'hFFFFFFFF, 32'h60, 1, 1, 32'h100,      1, 32'h22C);
    step("vec_mepc",      1, 1, 0, 0, CSR_MEPC,    0,            32'h64, 1, 1, 32'h60,       0, 32'h0);
    step("vec_mcause",    1, 1, 0, 0, CSR_MCAUSE,  0,            32'h68, 0, 0, 32'h8000000B, 0, 32'h0);
    step("vec_mst",       1, 1, 0, 0, CSR_MSTATUS, 0,            32'h6C, 0, 1, 32'h80,       0, 32'h0);
    step("mret2",         1, 0, 0, 1, CSR_MSTATUS, 0,            32'h70, 0, 1, 32'h0,        1, 32'h60);
    step("trap_vs_mret",  1, 0, 0, 1, CSR_MSTATUS, 0,            32'h74, 0, 1, 32'h0,        1, 32'h22C);
    step("tvm_mepc",      1, 1, 0, 0, CSR_MEPC,    0,            32'h22C, 0, 1, 32'h74,      0, 32'h0);
    step("tvm_mst",       1, 1, 0, 0, CSR_MSTATUS, 0,            32'h230, 0, 1, 32'h80,      0, 32'h0);
    step("mst_then_irq",  1, 1, 1, 0, CSR_MSTATUS, 32'h8,        32'h234, 0, 1, 32'h80,      0, 32'h0);
    step("new_mie_trap",  1, 0, 0, 0, CSR_MSTATUS, 0,            32'h90, 0, 1, 32'h0,        1, 32'h22C);

    // Reset lands mid-cycle while the trap is being requested
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid.redir", {31'b0, redirect}, 32'h0);
    check_eq("rst_mid.rpc", redirect_pc, 32'h0);
    read_in_reset("rst_mid.mstatus", CSR_MSTATUS);
    read_in_reset("rst_mid.mie",     CSR_MIE);
    read_in_reset("rst_mid.mtvec",   CSR_MTVEC);
    read_in_reset("rst_mid.mepc",    CSR_MEPC);
    read_in_reset("rst_mid.mcause",  CSR_MCAUSE);
    read_in_reset("rst_mid.mip",     CSR_MIP);
    csr_rd = 1'b0; ext_irq = 1'b0; inst_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step("post_rst_mepc", 1, 1, 0, 0, CSR_MEPC,    0,            0,    0, 0,  32'h0,        0, 32'h0);
    step("post_rst_mst",  1, 1, 0, 0, CSR_MSTATUS, 0,            0,    0, 0,  32'h0,        0, 32'h0);
    step("post_rst_tvec", 1, 1, 0, 0, CSR_MTVEC,   0,            0,    0, 0,  32'h0,        0, 32'h0);

    repeat (2) @(negedge clk);
    #1;
    check_eq("sb_drain", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
